// File: rtl/btn_pkg.sv
// -----------------------------------------------------------------------------
// btn_pkg
// Shared types and parameter-check helpers for the push-button debouncer.
//   state_e            : 2-bit debouncer FSM state encoding
//   debounce_cycles_ok : legality check for the debounce window length
//   long_cycles_ok     : legality check for the long-press hold time
// -----------------------------------------------------------------------------
package btn_pkg;

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      PRESS_WAIT   = 2'd1,
      PRESSED      = 2'd2,
      RELEASE_WAIT = 2'd3
   } state_e;

   // The window must span at least two samples to reject a single-cycle glitch.
   function automatic bit debounce_cycles_ok(input int unsigned debounce_cycles);
      return (debounce_cycles >= 2);
   endfunction

   // A long press only makes sense if it outlasts the debounce window.
   function automatic bit long_cycles_ok(input int unsigned debounce_cycles,
                                         input int unsigned long_cycles);
      return (long_cycles > debounce_cycles);
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Two-flop synchronizer for a single asynchronous level.
//   Parameter RST_VAL : value both flops take during reset
//   clk_i  in  destination clock
//   rst_i  in  asynchronous active-high reset
//   d_i    in  asynchronous input level
//   q_o    out synchronized level (two clk_i edges of latency)
// -----------------------------------------------------------------------------
module sync_2ff #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic q_o
);

   logic meta_q, meta_d;
   logic sync_q, sync_d;

   always_comb begin
      meta_d = d_i;
      sync_d = meta_q;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         meta_q <= RST_VAL;
         sync_q <= RST_VAL;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
// Push-button debouncer with press/release pulses and an optional long-press
// pulse. The long-press feature is built only when the macro
// BTN_DEBOUNCE_LONGPRESS_EN is defined; otherwise long_o is tied low.
//
//   Parameter DEBOUNCE_CYCLES : stable cycles needed to accept a level change
//   Parameter LONG_CYCLES     : hold time (from press_o) before long_o pulses
//
//   clk_i        in  system clock
//   rst_i        in  asynchronous active-high reset
//   btn_i        in  raw asynchronous button level, 1 = pressed
//   btn_o        out debounced level (registered)
//   press_o      out one-cycle pulse on accepted press (registered)
//   release_o    out one-cycle pulse on accepted release (registered)
//   long_o       out one-cycle pulse when a press has been held LONG_CYCLES
//   dbg_state_o  out current FSM state (state_e encoding), for observation
//
// Handshake: none; all outputs are plain registered levels/pulses.
// -----------------------------------------------------------------------------
module btn_debounce
   import btn_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 1000000,
   parameter int unsigned LONG_CYCLES     = 100000000
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       btn_i,
   output logic       btn_o,
   output logic       press_o,
   output logic       release_o,
   output logic       long_o,
   output logic [1:0] dbg_state_o
);

   localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
   // The counter holds the number of consecutive samples seen so far; the
   // state changes on the sample that would bring it to DEBOUNCE_CYCLES, so
   // it tops out at DEBOUNCE_CYCLES-1 and cannot wrap.
   localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

   if (!debounce_cycles_ok(DEBOUNCE_CYCLES)) begin : g_bad_debounce
      $error("btn_debounce: DEBOUNCE_CYCLES must be >= 2");
   end
   if (!long_cycles_ok(DEBOUNCE_CYCLES, LONG_CYCLES)) begin : g_bad_long
      $error("btn_debounce: LONG_CYCLES must exceed DEBOUNCE_CYCLES");
   end

   logic sync;

   sync_2ff #(
      .RST_VAL (1'b0)
   ) u_sync (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .d_i   (btn_i),
      .q_o   (sync)
   );

   state_e          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            btn_q, btn_d;
   logic            press_q, press_d;
   logic            release_q, release_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (sync) begin
               state_d = PRESS_WAIT;
               cnt_d   = CW'(1);
            end
         end
         PRESS_WAIT: begin
            if (!sync) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q == DB_LAST) begin
               state_d = PRESSED;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         PRESSED: begin
            if (!sync) begin
               state_d = RELEASE_WAIT;
               cnt_d   = CW'(1);
            end
         end
         RELEASE_WAIT: begin
            if (sync) begin
               state_d = PRESSED;
               cnt_d   = '0;
            end else if (cnt_q == DB_LAST) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Outputs are registered from the state, so they follow the state by one
   // cycle. The debounced level only rises on PRESS_WAIT->PRESSED and only
   // falls on RELEASE_WAIT->IDLE, so its edges are exactly the accepted
   // press/release events and can never coincide.
   always_comb begin
      btn_d     = (state_q == PRESSED) || (state_q == RELEASE_WAIT);
      press_d   = btn_d & ~btn_q;
      release_d = ~btn_d & btn_q;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         btn_q     <= 1'b0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         btn_q     <= btn_d;
         press_q   <= press_d;
         release_q <= release_d;
      end
   end

   assign btn_o       = btn_q;
   assign press_o     = press_q;
   assign release_o   = release_q;
   assign dbg_state_o = state_q;

`ifdef BTN_DEBOUNCE_LONGPRESS_EN
   localparam int unsigned LW = $clog2(LONG_CYCLES + 1);
   localparam logic [LW-1:0] LONG_MAX = LW'(LONG_CYCLES);

   logic [LW-1:0] long_cnt_q, long_cnt_d;
   logic          reached_q, reached_d;
   logic          long_q, long_d;

   // Counting starts at the state change into PRESSED, so the count reaches
   // LONG_CYCLES one cycle before press_o is LONG_CYCLES old, and the pulse
   // register lines long_o up with that moment. Release glitches stay in
   // PRESSED/RELEASE_WAIT and keep counting; an accepted release freezes the
   // count short of the limit, which suppresses the pulse.
   always_comb begin
      long_cnt_d = long_cnt_q;
      if ((state_q == PRESS_WAIT) && (state_d == PRESSED)) begin
         long_cnt_d = '0;
      end else if (((state_q == PRESSED) || (state_q == RELEASE_WAIT)) &&
                   (state_d != IDLE) && (long_cnt_q != LONG_MAX)) begin
         long_cnt_d = long_cnt_q + 1'b1;
      end
      reached_d = (long_cnt_q == LONG_MAX);
      long_d    = reached_d & ~reached_q;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         long_cnt_q <= '0;
         reached_q  <= 1'b0;
         long_q     <= 1'b0;
      end else begin
         long_cnt_q <= long_cnt_d;
         reached_q  <= reached_d;
         long_q     <= long_d;
      end
   end

   assign long_o = long_q;
`else
   assign long_o = 1'b0;
`endif

endmodule

// File: tb/tb_btn_debounce.sv
// -----------------------------------------------------------------------------
// tb_btn_debounce
// Directed bench for btn_debounce with DEBOUNCE_CYCLES=4, LONG_CYCLES=20.
// Inputs change 1 ns after a rising edge; outputs are checked 1 ns after the
// following rising edge. If btn_i is first sampled high at edge k, press_o and
// btn_o rise after edge k+6 (2 synchronizer edges + 4 debounce samples).
// -----------------------------------------------------------------------------
module tb_btn_debounce;

   localparam int unsigned DB = 4;
   localparam int unsigned LC = 20;
`ifdef BTN_DEBOUNCE_LONGPRESS_EN
   localparam bit LONG_EN = 1'b1;
`else
   localparam bit LONG_EN = 1'b0;
`endif

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_PRESSED = 2'd2;

   logic       clk = 1'b0;
   logic       rst;
   logic       btn;
   logic       btn_o;
   logic       press_o;
   logic       release_o;
   logic       long_o;
   logic [1:0] dbg_state;

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   btn_debounce #(
      .DEBOUNCE_CYCLES (DB),
      .LONG_CYCLES     (LC)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .btn_i       (btn),
      .btn_o       (btn_o),
      .press_o     (press_o),
      .release_o   (release_o),
      .long_o      (long_o),
      .dbg_state_o (dbg_state)
   );

   // ---------------- driver helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------- checkers ----------------
   task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic check_outs(input string tag, input logic eb, input logic ep,
                             input logic er, input logic el);
      check({tag, ".btn"},     {1'b0, btn_o},     {1'b0, eb});
      check({tag, ".press"},   {1'b0, press_o},   {1'b0, ep});
      check({tag, ".release"}, {1'b0, release_o}, {1'b0, er});
      check({tag, ".long"},    {1'b0, long_o},    {1'b0, el});
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      rst = 1'b1;
      btn = 1'b0;
      repeat (3) tick();
      check_outs("reset", 1'b0, 1'b0, 1'b0, 1'b0);
      check("reset.state", dbg_state, ST_IDLE);
      rst = 1'b0;
      repeat (2) tick();

      // Clean press: press_o/btn_o after edge k+6, press_o gone at k+7.
      btn = 1'b1;
      for (int j = 0; j <= 6; j++) begin
         tick();
         check_outs($sformatf("press_j%0d", j), (j >= 6), (j == 6), 1'b0, 1'b0);
      end
      check("press.state", dbg_state, ST_PRESSED);
      // Hold: one long_o pulse exactly LC cycles after press_o, never again.
      for (int i = 1; i <= 30; i++) begin
         tick();
         check_outs($sformatf("hold_i%0d", i), 1'b1, 1'b0, 1'b0, LONG_EN && (i == LC));
      end

      // Release glitch: two low samples, then high again; nothing changes.
      for (int j = 0; j < 10; j++) begin
         btn = !(j == 0 || j == 1);
         tick();
         check_outs($sformatf("rglitch_j%0d", j), 1'b1, 1'b0, 1'b0, 1'b0);
      end
      check("rglitch.state", dbg_state, ST_PRESSED);

      // Accepted release: release_o one cycle and btn_o low at edge k+6.
      btn = 1'b0;
      for (int j = 0; j <= 8; j++) begin
         tick();
         check_outs($sformatf("release_j%0d", j), (j < 6), 1'b0, (j == 6), 1'b0);
      end
      check("release.state", dbg_state, ST_IDLE);

      // Press glitch: high for 3 samples only; all outputs stay low.
      for (int j = 0; j <= 10; j++) begin
         btn = (j < 3);
         tick();
         check_outs($sformatf("pglitch_j%0d", j), 1'b0, 1'b0, 1'b0, 1'b0);
      end

      // Long press with a release glitch in between: count is not restarted.
      btn = 1'b1;
      for (int j = 0; j <= 6; j++) begin
         tick();
         check_outs($sformatf("lg_press_j%0d", j), (j >= 6), (j == 6), 1'b0, 1'b0);
      end
      for (int i = 1; i <= 24; i++) begin
         btn = !(i == 6 || i == 7);
         tick();
         check_outs($sformatf("lg_hold_i%0d", i), 1'b1, 1'b0, 1'b0, LONG_EN && (i == LC));
      end
      btn = 1'b0;
      for (int j = 0; j <= 7; j++) begin
         tick();
         check_outs($sformatf("lg_rel_j%0d", j), (j < 6), 1'b0, (j == 6), 1'b0);
      end

      // Short press released before LC: long_o must never fire.
      btn = 1'b1;
      for (int j = 0; j <= 6; j++) begin
         tick();
         check_outs($sformatf("sp_press_j%0d", j), (j >= 6), (j == 6), 1'b0, 1'b0);
      end
      for (int i = 1; i <= 5; i++) begin
         tick();
         check_outs($sformatf("sp_hold_i%0d", i), 1'b1, 1'b0, 1'b0, 1'b0);
      end
      btn = 1'b0;
      for (int j = 0; j <= 27; j++) begin
         tick();
         check_outs($sformatf("sp_rel_j%0d", j), (j < 6), 1'b0, (j == 6), 1'b0);
      end

      // Asynchronous reset while PRESSED: outputs drop with no clock edge.
      btn = 1'b1;
      repeat (9) tick();
      check("pre_arst.btn", {1'b0, btn_o}, 2'b01);
      #2;
      rst = 1'b1;
      #1;
      check_outs("arst", 1'b0, 1'b0, 1'b0, 1'b0);
      check("arst.state", dbg_state, ST_IDLE);
      btn = 1'b0;
      tick();
      rst = 1'b0;
      for (int j = 0; j < 8; j++) begin
         tick();
         check_outs($sformatf("post_arst_j%0d", j), 1'b0, 1'b0, 1'b0, 1'b0);
      end

      // Reset two cycles into PRESS_WAIT with btn held through it.
      btn = 1'b1;
      repeat (4) tick();
      rst = 1'b1;
      #1;
      check_outs("pw_rst", 1'b0, 1'b0, 1'b0, 1'b0);
      check("pw_rst.state", dbg_state, ST_IDLE);
      for (int j = 0; j < 3; j++) begin
         tick();
         check_outs($sformatf("pw_rst_hold_j%0d", j), 1'b0, 1'b0, 1'b0, 1'b0);
      end
      rst = 1'b0;
      // First edge after release samples btn (k); press after k+6.
      for (int j = 1; j <= 8; j++) begin
         tick();
         check_outs($sformatf("pw_after_j%0d", j), (j >= 7), (j == 7), 1'b0, 1'b0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
